// File: rtl/div_seq.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU sequencer that time-shares the execute-stage add/subtract unit.
// Optional macro DIV_SEQ_DBZ_FLAG_EN adds a dbz_o divide-by-zero flag output.
module div_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            busy_o,
  output logic            done_o,
`ifdef DIV_SEQ_DBZ_FLAG_EN
  output logic            dbz_o,
`endif
  output logic [XLEN-1:0] result_o,
  output logic [XLEN-1:0] as_a_o,
  output logic [XLEN-1:0] as_b_o,
  output logic            as_cin_o,
  input  logic [XLEN-1:0] as_result_i,
  input  logic            as_cout_i
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_NEG_A = 3'd1,
    S_NEG_B = 3'd2,
    S_ITER  = 3'd3,
    S_FIX_Q = 3'd4,
    S_FIX_R = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  ALL_ONES  = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]  MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  ZERO      = {XLEN{1'b0}};

  state_t            state_r, state_next_s;
  logic [1:0]        op_r, op_next_s;
  logic [XLEN-1:0]   dvd_r, dvd_next_s;
  logic [XLEN-1:0]   dvs_r, dvs_next_s;
  logic [XLEN-1:0]   rem_r, rem_next_s;
  logic [CNT_W-1:0]  cnt_r, cnt_next_s;
  logic              neg_q_r, neg_q_next_s;
  logic              neg_r_r, neg_r_next_s;
  logic [XLEN-1:0]   result_r, result_next_s;
  logic              done_r, done_next_s;
  logic              busy_r, busy_next_s;
  logic [XLEN-1:0]   as_a_r, as_a_next_s;
  logic [XLEN-1:0]   as_b_r, as_b_next_s;
  logic              as_cin_r, as_cin_next_s;
  logic [XLEN-1:0]   shifted_s;
  logic              qbit_s;
  logic [XLEN-1:0]   rem_fixed_s;
  logic              start_signed_s;
`ifdef DIV_SEQ_DBZ_FLAG_EN
  logic              dbz_r, dbz_next_s;
`endif

  // Next-state and datapath update for the divider FSM.
  always_comb begin
    state_next_s  = state_r;
    op_next_s     = op_r;
    dvd_next_s    = dvd_r;
    dvs_next_s    = dvs_r;
    rem_next_s    = rem_r;
    cnt_next_s    = cnt_r;
    neg_q_next_s  = neg_q_r;
    neg_r_next_s  = neg_r_r;
    result_next_s = result_r;
    done_next_s   = 1'b0;
`ifdef DIV_SEQ_DBZ_FLAG_EN
    dbz_next_s    = 1'b0;
`endif
    shifted_s      = {rem_r[XLEN-2:0], dvd_r[XLEN-1]};
    qbit_s         = rem_r[XLEN-1] | ~as_cout_i;
    rem_fixed_s    = neg_r_r ? as_result_i : rem_r;
    start_signed_s = ~op_i[0];

    case (state_r)
      S_IDLE: begin
        if (start_i) begin
          op_next_s  = op_i;
          dvd_next_s = rs1_i;
          dvs_next_s = rs2_i;
          if (rs2_i == ZERO) begin
            state_next_s  = S_DONE;
            result_next_s = op_i[1] ? rs1_i : ALL_ONES;
            done_next_s   = 1'b1;
`ifdef DIV_SEQ_DBZ_FLAG_EN
            dbz_next_s    = 1'b1;
`endif
          end else if (start_signed_s && (rs1_i == MIN_NEG) && (rs2_i == ALL_ONES)) begin
            state_next_s  = S_DONE;
            result_next_s = op_i[1] ? ZERO : MIN_NEG;
            done_next_s   = 1'b1;
          end else begin
            state_next_s = S_NEG_A;
          end
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_NEG_A: begin
        if (~op_r[0] && dvd_r[XLEN-1]) begin
          dvd_next_s = as_result_i;
        end else begin
          dvd_next_s = dvd_r;
        end
        neg_q_next_s = ~op_r[0] & (dvd_r[XLEN-1] ^ dvs_r[XLEN-1]);
        neg_r_next_s = ~op_r[0] & dvd_r[XLEN-1];
        state_next_s = S_NEG_B;
      end
      S_NEG_B: begin
        if (~op_r[0] && dvs_r[XLEN-1]) begin
          dvs_next_s = as_result_i;
        end else begin
          dvs_next_s = dvs_r;
        end
        rem_next_s   = ZERO;
        cnt_next_s   = {CNT_W{1'b0}};
        state_next_s = S_ITER;
      end
      S_ITER: begin
        // A set msb_out means the 33-bit partial remainder exceeds any divisor.
        rem_next_s = qbit_s ? as_result_i : shifted_s;
        dvd_next_s = {dvd_r[XLEN-2:0], qbit_s};
        cnt_next_s = cnt_r + CNT_W'(1);
        if (cnt_r == LAST_ITER) begin
          state_next_s = S_FIX_Q;
        end else begin
          state_next_s = S_ITER;
        end
      end
      S_FIX_Q: begin
        if (neg_q_r) begin
          dvd_next_s = as_result_i;
        end else begin
          dvd_next_s = dvd_r;
        end
        state_next_s = S_FIX_R;
      end
      S_FIX_R: begin
        rem_next_s    = rem_fixed_s;
        result_next_s = op_r[1] ? rem_fixed_s : dvd_r;
        done_next_s   = 1'b1;
        state_next_s  = S_DONE;
      end
      S_DONE: begin
        state_next_s = S_IDLE;
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase

    // A flush wins over every transition and suppresses the pending completion.
    if (kill_i && (state_r != S_IDLE)) begin
      state_next_s  = S_IDLE;
      result_next_s = result_r;
      done_next_s   = 1'b0;
`ifdef DIV_SEQ_DBZ_FLAG_EN
      dbz_next_s    = 1'b0;
`endif
    end else begin
      state_next_s = state_next_s;
    end

    busy_next_s = (state_next_s != S_IDLE);
  end

  // Adder operands are registered for the state being entered, from its register contents.
  always_comb begin
    as_a_next_s   = ZERO;
    as_b_next_s   = ZERO;
    as_cin_next_s = 1'b0;
    case (state_next_s)
      S_NEG_A: begin
        as_b_next_s   = dvd_next_s;
        as_cin_next_s = 1'b1;
      end
      S_NEG_B: begin
        as_b_next_s   = dvs_next_s;
        as_cin_next_s = 1'b1;
      end
      S_ITER: begin
        as_a_next_s   = {rem_next_s[XLEN-2:0], dvd_next_s[XLEN-1]};
        as_b_next_s   = dvs_next_s;
        as_cin_next_s = 1'b1;
      end
      S_FIX_Q: begin
        as_b_next_s   = dvd_next_s;
        as_cin_next_s = 1'b1;
      end
      S_FIX_R: begin
        as_b_next_s   = rem_next_s;
        as_cin_next_s = 1'b1;
      end
      default: begin
        as_a_next_s   = ZERO;
        as_b_next_s   = ZERO;
        as_cin_next_s = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r  <= S_IDLE;
      op_r     <= 2'b00;
      dvd_r    <= ZERO;
      dvs_r    <= ZERO;
      rem_r    <= ZERO;
      cnt_r    <= {CNT_W{1'b0}};
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      result_r <= ZERO;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
      as_a_r   <= ZERO;
      as_b_r   <= ZERO;
      as_cin_r <= 1'b0;
`ifdef DIV_SEQ_DBZ_FLAG_EN
      dbz_r    <= 1'b0;
`endif
    end else begin
      state_r  <= state_next_s;
      op_r     <= op_next_s;
      dvd_r    <= dvd_next_s;
      dvs_r    <= dvs_next_s;
      rem_r    <= rem_next_s;
      cnt_r    <= cnt_next_s;
      neg_q_r  <= neg_q_next_s;
      neg_r_r  <= neg_r_next_s;
      result_r <= result_next_s;
      done_r   <= done_next_s;
      busy_r   <= busy_next_s;
      as_a_r   <= as_a_next_s;
      as_b_r   <= as_b_next_s;
      as_cin_r <= as_cin_next_s;
`ifdef DIV_SEQ_DBZ_FLAG_EN
      dbz_r    <= dbz_next_s;
`endif
    end
  end

  assign busy_o   = busy_r;
  assign done_o   = done_r;
  assign result_o = result_r;
  assign as_a_o   = as_a_r;
  assign as_b_o   = as_b_r;
  assign as_cin_o = as_cin_r;
`ifdef DIV_SEQ_DBZ_FLAG_EN
  assign dbz_o    = dbz_r;
`endif

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed cases, early-outs, random ops against an arithmetic model,
// kill, mid-operation reset and start held across completion.
module tb_div_seq;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        kill_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] rs1_i = 32'd0;
  logic [31:0] rs2_i = 32'd0;
  logic        busy_o, done_o, as_cin_o;
  logic [31:0] result_o, as_a_o, as_b_o;
  logic [31:0] as_result_i;
  logic        as_cout_i;
`ifdef DIV_SEQ_DBZ_FLAG_EN
  logic        dbz_o;
`endif

  int vec = 0;
  int err = 0;

  always #5 clk_i = ~clk_i;

  // Shared add/subtract unit; on subtract the carry-out is the unsigned borrow.
  always_comb begin
    if (as_cin_o) {as_cout_i, as_result_i} = {1'b0, as_a_o} - {1'b0, as_b_o};
    else          {as_cout_i, as_result_i} = {1'b0, as_a_o} + {1'b0, as_b_o};
  end

  div_seq dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .kill_i(kill_i),
    .op_i(op_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .busy_o(busy_o), .done_o(done_o),
`ifdef DIV_SEQ_DBZ_FLAG_EN
    .dbz_o(dbz_o),
`endif
    .result_o(result_o), .as_a_o(as_a_o), .as_b_o(as_b_o), .as_cin_o(as_cin_o),
    .as_result_i(as_result_i), .as_cout_i(as_cout_i)
  );

  function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
    case (op)
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  // Edges from the start-sampling edge (counted as 1) to the edge raising done_o:
  // early-outs go straight to DONE; otherwise NEG_A, NEG_B, 32 ITER, FIX_Q, FIX_R precede DONE.
  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 37;
  endfunction

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output logic dz);
    int guard;
    guard = 0;
    @(negedge clk_i);
    while (busy_o && guard < 100) begin
      @(negedge clk_i);
      guard++;
    end
    start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    lat = 1;
    while (done_o !== 1'b1 && lat < 80) begin
      @(posedge clk_i); #1;
      lat++;
    end
    res = result_o;
`ifdef DIV_SEQ_DBZ_FLAG_EN
    dz = dbz_o;
`else
    dz = 1'b0;
`endif
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    vec++;
    if ({busy_o, done_o, as_cin_o} !== 3'b000 || result_o !== 32'd0 || as_a_o !== 32'd0 || as_b_o !== 32'd0) begin
      err++;
      $display("FAIL reset: busy=%b done=%b cin=%b res=%h a=%h b=%h, all must be 0",
               busy_o, done_o, as_cin_o, result_o, as_a_o, as_b_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  typedef struct {logic [1:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] exp; int lat;} dvec_t;

  task automatic test_directed();
    dvec_t tbl [10];
    logic [31:0] res;
    int lat;
    logic dz;
    tbl = '{
      '{2'b01, 32'd100,        32'd7,          32'd14,         37},
      '{2'b11, 32'd100,        32'd7,          32'd2,          37},
      '{2'b00, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  37},
      '{2'b10, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  37},
      '{2'b01, 32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          37},
      '{2'b11, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE,  37},
      '{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  1},
      '{2'b10, 32'd5,          32'd0,          32'd5,          1},
      '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1},
      '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1}
    };
    for (int i = 0; i < 10; i++) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, res, lat, dz);
      vec++;
      if (res !== tbl[i].exp) begin
        err++;
        $display("FAIL directed[%0d] result: got %h expected %h", i, res, tbl[i].exp);
      end
      vec++;
      if (lat !== tbl[i].lat) begin
        err++;
        $display("FAIL directed[%0d] latency: got %0d expected %0d", i, lat, tbl[i].lat);
      end
`ifdef DIV_SEQ_DBZ_FLAG_EN
      vec++;
      if (dz !== (tbl[i].b == 32'd0)) begin
        err++;
        $display("FAIL directed[%0d] dbz: got %b expected %b", i, dz, (tbl[i].b == 32'd0));
      end
`endif
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, res;
    logic [1:0] op;
    int lat;
    logic dz;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 20));
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = 32'hFFFF_FFFF;
        4: a = 32'h8000_0000;
        default: a = a;
      endcase
      do_op(op, a, b, res, lat, dz);
      vec++;
      if (res !== ref_model(op, a, b)) begin
        err++;
        $display("FAIL random[%0d] op=%0d %h/%h: got %h expected %h", i, op, a, b, res, ref_model(op, a, b));
      end
      vec++;
      if (lat !== ref_lat(op, a, b)) begin
        err++;
        $display("FAIL random[%0d] latency: got %0d expected %0d", i, lat, ref_lat(op, a, b));
      end
    end
  endtask

  task automatic test_kill();
    logic [31:0] res;
    int lat;
    logic dz;
    int seen;
    do_op(2'b11, 32'd100, 32'd7, res, lat, dz);
    @(negedge clk_i); @(negedge clk_i);
    start_i = 1'b1; op_i = 2'b01; rs1_i = 32'd100; rs2_i = 32'd7;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk_i);
    @(negedge clk_i);
    kill_i = 1'b1;
    @(posedge clk_i); #1;
    kill_i = 1'b0;
    vec++;
    if (busy_o !== 1'b0) begin
      err++;
      $display("FAIL kill busy: got %b expected 0", busy_o);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i); #1;
      if (done_o === 1'b1) seen++;
    end
    vec++;
    if (seen !== 0) begin
      err++;
      $display("FAIL kill done: got %0d done pulses expected 0", seen);
    end
    vec++;
    if (result_o !== 32'd2) begin
      err++;
      $display("FAIL kill result hold: got %h expected %h", result_o, 32'd2);
    end
    do_op(2'b11, 32'd9, 32'd4, res, lat, dz);
    vec++;
    if (res !== 32'd1 || lat !== 37) begin
      err++;
      $display("FAIL after-kill REMU 9/4: got %h in %0d expected 1 in 37", res, lat);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    int lat;
    logic dz;
    @(negedge clk_i);
    start_i = 1'b1; op_i = 2'b00; rs1_i = 32'hFFFF_FF9C; rs2_i = 32'd7;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (20) @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    vec++;
    if ({busy_o, done_o, as_cin_o} !== 3'b000 || result_o !== 32'd0 || as_a_o !== 32'd0 || as_b_o !== 32'd0) begin
      err++;
      $display("FAIL reset-mid: busy=%b done=%b cin=%b res=%h a=%h b=%h, all must be 0",
               busy_o, done_o, as_cin_o, result_o, as_a_o, as_b_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    do_op(2'b01, 32'd100, 32'd7, res, lat, dz);
    vec++;
    if (res !== 32'd14) begin
      err++;
      $display("FAIL reset-mid recovery: got %h expected %h", res, 32'd14);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk_i); @(negedge clk_i);
    start_i = 1'b1; op_i = 2'b01; rs1_i = 32'd1000; rs2_i = 32'd9;
    @(posedge clk_i); #1;
    // start stays high with new operands; they must not be taken while busy
    op_i = 2'b11; rs1_i = 32'd50; rs2_i = 32'd6;
    n = 1;
    while (done_o !== 1'b1 && n < 80) begin
      @(posedge clk_i); #1;
      n++;
    end
    vec++;
    if (result_o !== 32'd111 || n !== 37) begin
      err++;
      $display("FAIL b2b first: got %h in %0d expected %h in 37", result_o, n, 32'd111);
    end
    @(posedge clk_i); #1;
    vec++;
    if (busy_o !== 1'b0) begin
      err++;
      $display("FAIL b2b idle gap busy: got %b expected 0", busy_o);
    end
    @(posedge clk_i); #1;
    start_i = 1'b0;
    vec++;
    if (busy_o !== 1'b1) begin
      err++;
      $display("FAIL b2b second accept busy: got %b expected 1", busy_o);
    end
    n = 1;
    while (done_o !== 1'b1 && n < 80) begin
      @(posedge clk_i); #1;
      n++;
    end
    vec++;
    if (result_o !== 32'd2 || n !== 37) begin
      err++;
      $display("FAIL b2b second: got %h in %0d expected %h in 37", result_o, n, 32'd2);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_kill();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
